// File: rtl/cla_serial_add_seq.sv
`default_nettype none
// ============================================================================
// cla_serial_add_seq : 32-bit adder that reuses one SLICE-bit CLA per cycle,
//                      LSB slice first, with valid/ready in and out.
// Revision 1.0
// ============================================================================
module cla_serial_add_seq #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int c_NSLICE = WIDTH / SLICE;
    localparam int c_KW     = (c_NSLICE > 1) ? $clog2(c_NSLICE) : 1;
    localparam logic [c_KW-1:0] c_KLAST = c_KW'(c_NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;
    logic [c_KW-1:0]   k_q, k_d;

    logic [SLICE-1:0]  w_a_sl;
    logic [SLICE-1:0]  w_b_sl;
    logic [SLICE-1:0]  w_slice_sum;
    logic              w_slice_cout;

    assign w_a_sl = a_q[k_q*SLICE +: SLICE];
    assign w_b_sl = b_q[k_q*SLICE +: SLICE];

    // Each carry is a flat sum-of-products of generates/propagates, not a ripple.
    always_comb begin : p_cla
        logic [SLICE-1:0] g;
        logic [SLICE-1:0] p;
        logic [SLICE:0]   c;
        logic             prod;
        g    = w_a_sl & w_b_sl;
        p    = w_a_sl ^ w_b_sl;
        c    = '0;
        prod = 1'b0;
        c[0] = carry_q;
        for (int i = 0; i < SLICE; i++) begin
            c[i+1] = g[i];
            prod   = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (prod & g[j]);
                prod   = prod & p[j];
            end
            c[i+1] = c[i+1] | (prod & carry_q);
        end
        w_slice_sum  = p ^ c[SLICE-1:0];
        w_slice_cout = c[SLICE];
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        k_d     = k_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B;
                    carry_d = cin;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[k_q*SLICE +: SLICE] = w_slice_sum;
                carry_d = w_slice_cout;
                k_d     = k_q + 1'b1;
                if (k_q == c_KLAST) begin
                    cout_d  = w_slice_cout;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            k_q     <= k_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_cla_serial_add_seq.sv
`default_nettype none
// Directed and random checks of cla_serial_add_seq against hand-computed sums.
module tb_cla_serial_add_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
    logic        busy;

    int errors;
    int checks;

    cla_serial_add_seq #(.WIDTH(32), .SLICE(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one operand set; accepted at the next edge (caller ensures IDLE).
    task automatic accept(input logic [31:0] a, input logic [31:0] b, input logic c);
        A        = a;
        B        = b;
        cin      = c;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            step();
            cyc++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({in_ready, out_valid, busy, cout} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_ctrl: in_ready/out_valid/busy/cout=%b required 1000",
                     {in_ready, out_valid, busy, cout});
        end
        checks++;
        if (sum !== 32'h0) begin
            errors++;
            $display("FAIL reset_sum: got %h required 00000000", sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_carry_chain();
        int cyc;
        logic bad;
        bad = 1'b0;
        accept(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            if (busy !== 1'b1 || in_ready !== 1'b0) bad = 1'b1;
            step();
            cyc++;
        end
        checks++;
        if (cyc !== 8) begin
            errors++;
            $display("FAIL chain_latency: got %0d cycles required 8", cyc);
        end
        checks++;
        if (bad || busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL chain_busy: busy/in_ready wrong during operation, now busy=%b in_ready=%b required 1/0",
                     busy, in_ready);
        end
        checks++;
        if ({cout, sum} !== 33'h1_0000_0000) begin
            errors++;
            $display("FAIL chain_result: got cout=%b sum=%h required 1 00000000", cout, sum);
        end
        consume();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL chain_return: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int nacc;
        int nres;
        int gap;
        logic [32:0] res [2];
        nacc = 0;
        nres = 0;
        gap  = 0;
        out_ready = 1'b1;
        A = 32'h1234_5678;
        B = 32'h8765_4321;
        cin = 1'b1;
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 60 && nres < 2; cyc++) begin
            if (out_valid && nres < 2) begin
                res[nres] = {cout, sum};
                nres++;
            end
            if (in_ready && in_valid) begin
                nacc++;
                step();
                if (nacc == 1) begin
                    A = 32'h7FFF_FFFF;
                    B = 32'h7FFF_FFFF;
                    cin = 1'b0;
                end else begin
                    in_valid = 1'b0;
                end
            end else begin
                if (nacc == 1) gap++;
                step();
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (nres !== 2) begin
            errors++;
            $display("FAIL b2b_count: got %0d results required 2", nres);
        end else begin
            checks++;
            if (res[0] !== 33'h0_9999_999A) begin
                errors++;
                $display("FAIL b2b_first: got %h required 09999999a", res[0]);
            end
            checks++;
            if (res[1] !== 33'h0_FFFF_FFFE) begin
                errors++;
                $display("FAIL b2b_second: got %h required 0fffffffe", res[1]);
            end
        end
        // 8 RUN + 1 DONE cycles with in_ready low between the two accepts.
        checks++;
        if (gap !== 9) begin
            errors++;
            $display("FAIL b2b_interval: got %0d not-ready cycles required 9", gap);
        end
        step();
    endtask

    task automatic test_backpressure();
        int cyc;
        logic bad;
        bad = 1'b0;
        out_ready = 1'b0;
        accept(32'h8000_0000, 32'h8000_0000, 1'b0);
        wait_valid(cyc);
        checks++;
        if (cyc !== 8) begin
            errors++;
            $display("FAIL bp_latency: got %0d cycles required 8", cyc);
        end
        for (int i = 0; i < 5; i++) begin
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 32'h0 || cout !== 1'b1) bad = 1'b1;
            step();
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL bp_hold: result or handshake moved while stalled, now sum=%h cout=%b required 00000000 1",
                     sum, cout);
        end
        consume();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b busy=%b required 1/0/0",
                     in_ready, out_valid, busy);
        end
    endtask

    task automatic test_isolation();
        int cyc;
        accept(32'hAAAA_AAAA, 32'h5555_5555, 1'b0);
        A   = 32'h0;
        B   = 32'h0;
        cin = 1'b1;
        wait_valid(cyc);
        checks++;
        if ({cout, sum} !== 33'h0_FFFF_FFFF || cyc !== 8) begin
            errors++;
            $display("FAIL isolation: got cout=%b sum=%h after %0d cycles required 0 ffffffff after 8",
                     cout, sum, cyc);
        end
        consume();
    endtask

    task automatic test_reset_mid();
        int cyc;
        logic seen;
        seen = 1'b0;
        accept(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        step();
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, busy, cout} !== 4'b1000 || sum !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid: in_ready/out_valid/busy/cout=%b sum=%h required 1000 00000000",
                     {in_ready, out_valid, busy, cout}, sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (out_valid !== 1'b0) seen = 1'b1;
            step();
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_no_result: out_valid seen after abort, required none");
        end
        accept(32'h0000_0001, 32'h0000_0001, 1'b1);
        wait_valid(cyc);
        checks++;
        if ({cout, sum} !== 33'h0_0000_0003 || cyc !== 8) begin
            errors++;
            $display("FAIL reset_next_op: got cout=%b sum=%h after %0d cycles required 0 00000003 after 8",
                     cout, sum, cyc);
        end
        consume();
    endtask

    task automatic test_random();
        int cyc;
        int stall;
        logic [31:0] a;
        logic [31:0] b;
        logic        c;
        logic [32:0] exp;
        for (int n = 0; n < 200; n++) begin
            a   = $urandom;
            b   = $urandom;
            c   = 1'($urandom_range(0, 1));
            exp = {1'b0, a} + {1'b0, b} + {32'b0, c};
            accept(a, b, c);
            wait_valid(cyc);
            stall = $urandom_range(0, 3);
            for (int i = 0; i < stall; i++) step();
            checks++;
            if ({cout, sum} !== exp || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL random_%0d: %h+%h+%b got valid=%b cout=%b sum=%h required %h",
                         n, a, b, c, out_valid, cout, sum, exp);
            end
            consume();
        end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = 32'h0;
        B         = 32'h0;
        cin       = 1'b0;
        test_reset();
        test_carry_chain();
        test_back_to_back();
        test_backpressure();
        test_isolation();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
